// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// opcodes, ALUOp codes, datapath mux selects and ALU operation codes.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RS_ALUOUT    = 2'b00;
   localparam logic [1:0] RS_DATA      = 2'b01;
   localparam logic [1:0] RS_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU_Decoder: maps ALUOp plus instruction fields onto the ALU operation.
module ALU_Decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [1:0] ALUOp,
   input  logic [2:0] Funct3,
   input  logic       Funct7_5,
   input  logic       Op_5,
   output logic [2:0] ALUControl
);

   // Select the ALU operation; sub only for R-type with funct7[5] set
   always_comb begin
      ALUControl = ALU_ADD;
      case (ALUOp)
         ALUOP_ADD: ALUControl = ALU_ADD;
         ALUOP_SUB: ALUControl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (Funct3)
               3'b000:  ALUControl = (Op_5 & Funct7_5) ? ALU_SUB : ALU_ADD;
               3'b010:  ALUControl = ALU_SLT;
               3'b110:  ALUControl = ALU_OR;
               3'b111:  ALUControl = ALU_AND;
               default: ALUControl = ALU_ADD;
            endcase
         end
         default: ALUControl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore sequencing FSM for the multi-cycle RV32I datapath sharing one
// cache port; stalls in fetch and memory states on Mem_Ready.
module multicycle_control_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter state_t RESET_STATE        = S_FETCH,
   parameter bit     ALLOW_ILLEGAL_TRAP = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] Opcode,
   input  logic [2:0] Funct3,
   input  logic       Funct7_5,
   input  logic       Zero,
   input  logic       Mem_Ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       Illegal
);

   state_t     state_q, state_d;

   logic       pc_update, branch;
   logic       adr_src, ir_write, mem_read, mem_write, reg_write, illegal;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
   logic [2:0] alu_ctrl;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= RESET_STATE;
      else     state_q <= state_d;
   end

   // Next-state and per-state control decode
   always_comb begin
      state_d    = S_FETCH;
      pc_update  = 1'b0;
      branch     = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
      result_src = RS_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            mem_read   = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RS_ALURESULT;
            ir_write   = Mem_Ready;
            pc_update  = Mem_Ready;
            state_d    = Mem_Ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (Opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECR;
               OP_ITYPE:     state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default: begin
                  illegal = ALLOW_ILLEGAL_TRAP;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            state_d   = Opcode[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src  = 1'b1;
            mem_read = 1'b1;
            state_d  = Mem_Ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            result_src = RS_DATA;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
            state_d   = Mem_Ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
         end
         S_BEQ: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            alu_op    = ALUOP_SUB;
            branch    = 1'b1;
         end
         S_JAL: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_update = 1'b1;
            state_d   = S_ALUWB;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Immediate format follows the opcode regardless of state
   always_comb begin
      case (Opcode)
         OP_SW:   imm_src = IMM_S;
         OP_BEQ:  imm_src = IMM_B;
         OP_JAL:  imm_src = IMM_J;
         default: imm_src = IMM_I;
      endcase
   end

   ALU_Decoder u_alu_decoder (
      .ALUOp      (alu_op),
      .Funct3     (Funct3),
      .Funct7_5   (Funct7_5),
      .Op_5       (Opcode[5]),
      .ALUControl (alu_ctrl)
   );

   // Output drive; reset kills every control immediately, aborting any access
   always_comb begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = '0;
      ALUSrcA    = '0;
      ALUSrcB    = '0;
      ImmSrc     = '0;
      ALUControl = '0;
      Illegal    = 1'b0;
      if (!rst) begin
         PCWrite    = pc_update | (branch & Zero);
         AdrSrc     = adr_src;
         IRWrite    = ir_write;
         MemRead    = mem_read;
         MemWrite   = mem_write;
         RegWrite   = reg_write;
         ResultSrc  = result_src;
         ALUSrcA    = alu_src_a;
         ALUSrcB    = alu_src_b;
         ImmSrc     = imm_src;
         ALUControl = alu_ctrl;
         Illegal    = illegal;
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed-vector bench for multicycle_control_fsm. Each vector drives the
// inputs for one cycle and compares all outputs, packed, against a
// hand-computed value.
module tb_multicycle_control_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] Opcode;
   logic [2:0] Funct3;
   logic       Funct7_5;
   logic       Zero;
   logic       Mem_Ready;
   logic       PCWrite, AdrSrc, IRWrite, MemRead, MemWrite, RegWrite, Illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   multicycle_control_fsm #(.RESET_STATE(riscv_ctrl_pkg::S_FETCH), .ALLOW_ILLEGAL_TRAP(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .Opcode     (Opcode),
      .Funct3     (Funct3),
      .Funct7_5   (Funct7_5),
      .Zero       (Zero),
      .Mem_Ready  (Mem_Ready),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .IRWrite    (IRWrite),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .Illegal    (Illegal)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] BEQ = 7'b1100011;
   localparam logic [6:0] JAL = 7'b1101111;
   localparam logic [6:0] BAD = 7'b0000000;

   // Packing: {PCWrite,AdrSrc,IRWrite,MemRead,MemWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,Illegal}
   function automatic logic [17:0] ev(input logic pcw, adr, irw, mrd, mwr, rw,
                                      input logic [1:0] rs, sa, sb, imm,
                                      input logic [2:0] alu, input logic ill);
      return {pcw, adr, irw, mrd, mwr, rw, rs, sa, sb, imm, alu, ill};
   endfunction

   task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%05h expected=%05h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, compare at the falling edge, step past the rising edge
   task automatic vec(input string tag, input logic r, input logic [6:0] op,
                      input logic [2:0] f3, input logic f7, input logic z,
                      input logic mr, input logic [17:0] exp);
      rst = r; Opcode = op; Funct3 = f3; Funct7_5 = f7; Zero = z; Mem_Ready = mr;
      @(negedge clk);
      check(tag, {PCWrite, AdrSrc, IRWrite, MemRead, MemWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal}, exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; Opcode = RT; Funct3 = 3'b000; Funct7_5 = 1'b0; Zero = 1'b0; Mem_Ready = 1'b1;

      // Reset: everything low
      for (int i = 0; i < 2; i++)
         vec("reset", 1'b1, RT, 3'b000, 1'b0, 1'b0, 1'b1, '0);

      // add: fetch, decode, execR, aluwb
      vec("add_fetch",  1'b0, RT, 3'b000, 1'b0, 1'b0, 1'b1, ev(1,0,1,1,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
      vec("add_decode", 1'b0, RT, 3'b000, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0));
      vec("add_execr",  1'b0, RT, 3'b000, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 0));
      vec("add_aluwb",  1'b0, RT, 3'b000, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));

      // sub: funct7[5] set on an R-type selects subtract
      vec("sub_fetch",  1'b0, RT, 3'b000, 1'b1, 1'b0, 1'b1, ev(1,0,1,1,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
      vec("sub_decode", 1'b0, RT, 3'b000, 1'b1, 1'b0, 1'b1, ev(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0));
      vec("sub_execr",  1'b0, RT, 3'b000, 1'b1, 1'b0, 1'b1, ev(0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0));
      vec("sub_aluwb",  1'b0, RT, 3'b000, 1'b1, 1'b0, 1'b1, ev(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));

      // lw with three stall cycles in memread: 8 cycles total
      vec("lw_fetch",   1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, ev(1,0,1,1,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
      vec("lw_decode",  1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0));
      vec("lw_memadr",  1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
      for (int i = 0; i < 3; i++)
         vec("lw_memread_stall", 1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b0, ev(0,1,0,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      vec("lw_memread_done", 1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, ev(0,1,0,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      vec("lw_memwb",   1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0));

      // sw with five stall cycles: MemWrite for six cycles, then fetch
      vec("sw_fetch",   1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b1, ev(1,0,1,1,0,0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0));
      vec("sw_decode",  1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 0));
      vec("sw_memadr",  1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
      for (int i = 0; i < 5; i++)
         vec("sw_memwrite_stall", 1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b0, ev(0,1,0,0,1,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
      vec("sw_memwrite_done", 1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b1, ev(0,1,0,0,1,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));

      // beq taken; Zero high in decode must not write the PC
      vec("beq1_fetch",  1'b0, BEQ, 3'b000, 1'b0, 1'b1, 1'b1, ev(1,0,1,1,0,0, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0));
      vec("beq1_decode", 1'b0, BEQ, 3'b000, 1'b0, 1'b1, 1'b1, ev(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 0));
      vec("beq1_branch", 1'b0, BEQ, 3'b000, 1'b0, 1'b1, 1'b1, ev(1,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));
      // beq not taken
      vec("beq0_fetch",  1'b0, BEQ, 3'b000, 1'b0, 1'b0, 1'b1, ev(1,0,1,1,0,0, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0));
      vec("beq0_decode", 1'b0, BEQ, 3'b000, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 0));
      vec("beq0_branch", 1'b0, BEQ, 3'b000, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));

      // jal: PC written in S_JAL, OldPC+4 written back in aluwb
      vec("jal_fetch",  1'b0, JAL, 3'b000, 1'b0, 1'b0, 1'b1, ev(1,0,1,1,0,0, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000, 0));
      vec("jal_decode", 1'b0, JAL, 3'b000, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b11, 3'b000, 0));
      vec("jal_jump",   1'b0, JAL, 3'b000, 1'b0, 1'b0, 1'b1, ev(1,0,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0));
      vec("jal_aluwb",  1'b0, JAL, 3'b000, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 0));

      // Unknown opcode with one fetch stall; Illegal pulses once in decode
      vec("ill_fetch_stall", 1'b0, BAD, 3'b000, 1'b0, 1'b0, 1'b0, ev(0,0,0,1,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
      vec("ill_fetch",  1'b0, BAD, 3'b000, 1'b0, 1'b0, 1'b1, ev(1,0,1,1,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
      vec("ill_decode", 1'b0, BAD, 3'b000, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1));

      // sw interrupted by reset during the write stall
      vec("swr_fetch",  1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b1, ev(1,0,1,1,0,0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0));
      vec("swr_decode", 1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 0));
      vec("swr_memadr", 1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
      vec("swr_stall",  1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b0, ev(0,1,0,0,1,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
      vec("swr_reset",  1'b1, SW, 3'b010, 1'b0, 1'b0, 1'b0, '0);
      vec("swr_refetch", 1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b1, ev(1,0,1,1,0,0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequencing controller for the multi-cycle RV32I datapath variant; replaces the single-cycle control unit when the core shares one cache port for instructions and data.
- Moore FSM drives datapath enables and mux selects per state.
- Stalls in fetch and memory states on the cache's Mem_Ready handshake, so multi-cycle write-through stores and misses are absorbed without datapath changes.
- Feeds ALUOp to the existing ALU_Decoder instance for ALUControl.

Parameters:
- RESET_STATE, 4'd0 (S_FETCH), state entered on reset.
- ALLOW_ILLEGAL_TRAP, 1, 1 = pulse Illegal and return to S_FETCH on unknown opcode; 0 = treat as NOP.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- Opcode  in  7  instruction register [6:0]
- Funct3  in  3  instruction register [14:12]
- Funct7_5  in  1  instruction register [30]
- Zero  in  1  ALU zero flag
- Mem_Ready  in  1  cache done or ready for current MemRead/MemWrite
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0 = PC, 1 = ALUOut to memory address
- IRWrite  out  1  instruction register and OldPC enable
- MemRead  out  1  cache read strobe
- MemWrite  out  1  cache write strobe
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1
- ALUSrcB  out  2  00 rs2, 01 Imm, 10 constant 4
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- ALUControl  out  3  from ALU_Decoder
- Illegal  out  1  one-cycle pulse on unknown opcode

Behaviour:
- Reset: synchronous, active-high. At the clk edge with rst=1, state <= S_FETCH. While rst=1, all outputs are forced to 0 combinationally. A reset mid-access drops MemRead/MemWrite immediately; the aborted access is not retried.
- Outputs are decoded from the state. Exceptions:
  - PCWrite = PCUpdate | (Branch & Zero).
  - In waiting states, IRWrite and PCUpdate are gated by Mem_Ready.
- ImmSrc decodes from Opcode in every state: lw/I = 00, sw = 01, beq = 10, jal = 11.
- States and the controls each one asserts:
  - S_FETCH: AdrSrc=0, MemRead=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate fire only when Mem_Ready=1; otherwise hold.
  - S_DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target into ALUOut). Next state by Opcode:
    - 0000011 or 0100011 -> S_MEMADR
    - 0110011 -> S_EXECR
    - 0010011 -> S_EXECI
    - 1100011 -> S_BEQ
    - 1101111 -> S_JAL
    - other -> Illegal pulse, S_FETCH
  - S_MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next S_MEMREAD if Opcode[5]=0, else S_MEMWRITE.
  - S_MEMREAD: AdrSrc=1, MemRead=1. Holds until Mem_Ready, then S_MEMWB.
  - S_MEMWB: ResultSrc=01, RegWrite=1. Next S_FETCH.
  - S_MEMWRITE: AdrSrc=1, MemWrite=1. Holds until Mem_Ready (write-through latency), then S_FETCH.
  - S_EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next S_ALUWB.
  - S_EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next S_ALUWB.
  - S_ALUWB: ResultSrc=00, RegWrite=1. Next S_FETCH.
  - S_BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next S_FETCH.
  - S_JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next S_ALUWB (writes OldPC+4).
- Latency in cycles, with Mem_Ready already high:
  - lw = 5
  - sw = 4
  - R-type and I-type = 4
  - beq = 3
  - jal = 4
- Each cycle Mem_Ready is low in a waiting state adds one cycle.
- Strobes and the address mux stay stable while waiting.
- Mem_Ready high in a non-memory state is ignored.
- Unreachable state codes go to S_FETCH with all outputs 0.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state encoding localparams (4-bit)
  - opcode constants
  - ALUOp codes
  - ResultSrc, ALUSrcA and ALUSrcB select constants
- Sub-module: the existing ALU_Decoder, fed ALUOp, Funct3, Funct7_5 and Opcode[5].
- Everything else stays in one FSM module.

Test Plan:
- Reset: rst=1 for 2 cycles, Mem_Ready=1 -> all outputs 0 during reset. The first cycle after release is S_FETCH with MemRead=1 and IRWrite=1.
- add (0110011, Funct3=000, Funct7_5=0), Mem_Ready=1 -> 4 cycles. ALUControl=000 in S_EXECR; RegWrite=1 only in cycle 4.
- lw with Mem_Ready low for 3 cycles in S_MEMREAD -> MemRead and AdrSrc held for 4 cycles. Total 8 cycles; RegWrite with ResultSrc=01 once.
- sw with write-through stall of 5 cycles -> MemWrite=1 for exactly 6 consecutive cycles, then S_FETCH. No RegWrite asserted.
- beq: Zero=1 -> PCWrite=1 in cycle 3. Zero=0 -> PCWrite=0; the next fetch comes from PC+4.
- Unknown opcode 0000000 -> Illegal pulses once in S_DECODE, then back to S_FETCH. Separately: rst asserted during the S_MEMWRITE stall -> MemWrite=0 in the same cycle.
